mips_mem_arbiter: RTL and testbench
===================================

// Module: mips_mem_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM (1-cycle read latency) between the multicycle MIPS
//  instruction-fetch requester (I, read-only) and the load/store requester (D, read/write).
//  Sits between the core control FSM and the unified memory; sequences each access as
//  grant -> issue -> capture -> ack, with one owner at a time.
// PARAMETERS
//  ADDR_W  10  word-address width (1024 x 32 memory)
//  DATA_W  32  data width
// PORTS
//  clk          in   1       system clock; all logic on posedge
//  rst          in   1       synchronous, active-high reset
//  i_req        in   1       fetch request; held high until i_ack seen
//  i_addr       in   ADDR_W  fetch word address; stable while i_req high
//  i_ack        out  1       one-cycle pulse: i_rdata valid
//  i_rdata      out  DATA_W  fetched instruction, held until next I ack
//  d_req        in   1       data request; held high until d_ack seen
//  d_we         in   1       1 = store, 0 = load; stable while d_req high
//  d_addr       in   ADDR_W  data word address
//  d_wdata      in   DATA_W  store data
//  d_ack        out  1       one-cycle pulse: load data valid / store done
//  d_rdata      out  DATA_W  load data, held until next D load ack
//  mem_address  out  ADDR_W  RAM address (registered)
//  mem_data     out  DATA_W  RAM write data (registered)
//  mem_wren     out  1       RAM write enable (registered, one cycle max)
//  mem_q        in   DATA_W  RAM read data, valid the cycle after address sampled
//  busy         out  1       high in any state but IDLE
//  owner_d      out  1       1 = D holds memory, 0 = I (valid while busy)
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; rr pointer favours D.
//  - FSM IDLE -> ISSUE -> CAPTURE -> DONE -> IDLE, one edge per transition.
//  - IDLE: if any req, pick winner, register mem_address/mem_data/mem_wren(=d_we&owner_d),
//    owner_d, go ISSUE; else stay, mem_wren=0.
//  - ISSUE: RAM samples address/wren this edge (store committed); clear mem_wren; -> CAPTURE.
//  - CAPTURE: latch mem_q into owner's rdata (not for stores); pulse owner's ack; -> DONE.
//  - DONE: ack high this cycle; req inputs ignored; -> IDLE on next edge.
//  - Latency: req sampled at edge E0 -> ack high E2..E3 -> next grant earliest at E4.
//    Requester must drop req at the edge it samples ack (E3).
//  - Only the owner's ack ever pulses; i_ack and d_ack never high together.
//  - Simultaneous I and D req in IDLE: D wins (fixed priority) unless RR enabled.
//  - Req dropped mid-transaction: transaction still completes and acks.
//  - rst asserted in ISSUE: store already presented at that edge completes in RAM; no ack.
//    rst in any state: -> IDLE, outputs cleared same edge, no ack.
//  - Addresses pass unmodified; no wrap or range check (ADDR_W bits wrap naturally).
// CONFIGURATION
//  MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous req, winner = requester NOT granted last;
//    pointer updates on every grant. Single requester always granted.
//  Undefined: fixed priority, D over I; pointer logic absent.
// STRUCTURE
//  Shared package mips_mem_pkg: FSM state encodings (IDLE/ISSUE/CAPTURE/DONE, 2 bits),
//  OWNER_I/OWNER_D constants, default ADDR_W/DATA_W.
//  One sub-module: mem_arb_pick (combinational winner select + RR pointer register
//  under MEM_ARB_ROUND_ROBIN_EN).
// TESTING
//  1 I-only: i_req, i_addr=0x004, RAM[4]=0x20080005 -> i_ack 2 cycles after grant,
//    i_rdata=0x20080005, mem_wren never 1.
//  2 D store then load: d_we=1 addr=0x010 wdata=0xDEADBEEF -> mem_wren one cycle,
//    d_ack; then d_we=0 addr=0x010 -> d_rdata=0xDEADBEEF.
//  3 Simultaneous I(0x001)+D(0x002), fixed priority -> D acked first, I acked 4 cycles
//    later; with MEM_ARB_ROUND_ROBIN_EN, two back-to-back contentions -> D then I, then I
//    first on third if D last.
//  4 Back-to-back I reqs held continuously -> exactly one ack per 4 cycles, no double ack.
//  5 rst high in ISSUE of store to 0x020 (0x12345678) -> no d_ack, busy=0 next cycle,
//    later load of 0x020 returns 0x12345678.
//  6 Reset values: after rst, all outputs 0 and busy=0 with both req low.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS unified-memory arbiter.
// Holds the arbiter FSM state encoding, the owner encoding and default bus widths.
package mips_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } arb_state_e;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the memory arbiter.
// Build option: MEM_ARB_ROUND_ROBIN_EN adds a last-grant pointer so contention
// alternates; without it D always beats I.
// Ports:
//   clk, rst, grant (round-robin build only) - pointer clock, sync reset, grant strobe
//   i_req, d_req                             - requests from fetch and load/store
//   pick_d_c                                 - combinational: 1 = D wins, 0 = I wins
module mem_arb_pick
    import mips_mem_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic clk,
    input  logic rst,
    input  logic grant,
`endif
    input  logic i_req,
    input  logic d_req,
    output logic pick_d_c
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Owner of the most recent grant; resetting to I makes D win the first tie.
    logic last_d_q;

    always_comb begin
        pick_d_c = d_req;
        if (i_req && d_req) begin
            pick_d_c = ~last_d_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_q <= OWNER_I;
        end else if (grant) begin
            last_d_q <= pick_d_c;
        end
    end
`else
    // D wins whenever it asks; I only when it is alone.
    assign pick_d_c = d_req | ~i_req;
`endif

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM (1-cycle read latency) between
// the instruction-fetch requester (I, read-only) and the load/store requester (D).
// Each access runs IDLE -> ISSUE -> CAPTURE -> DONE with a single owner.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of D-first priority.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   i_req, i_addr, i_ack, i_rdata     - fetch request / address / ack pulse / data
//   d_req, d_we, d_addr, d_wdata      - load/store request, write enable, address, data
//   d_ack, d_rdata                    - load/store ack pulse / load data
//   mem_address, mem_data, mem_wren   - registered RAM address, write data, write enable
//   mem_q                             - RAM read data (valid cycle after address sampled)
//   busy, owner_d                     - transaction in flight / D owns the memory
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy,
    output logic              owner_d
);

    arb_state_e        state_q;
    arb_state_e        state_nxt;
    logic              pick_d_c;
    logic              grant_c;
    logic              store_q;
    logic              store_nxt;
    logic              i_ack_nxt;
    logic              d_ack_nxt;
    logic              mem_wren_nxt;
    logic              busy_nxt;
    logic              owner_d_nxt;
    logic [DATA_W-1:0] i_rdata_nxt;
    logic [DATA_W-1:0] d_rdata_nxt;
    logic [DATA_W-1:0] mem_data_nxt;
    logic [ADDR_W-1:0] mem_address_nxt;

    assign grant_c = (state_q == ST_IDLE) && (i_req || d_req);

    mem_arb_pick u_pick (
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .clk      (clk),
        .rst      (rst),
        .grant    (grant_c),
`endif
        .i_req    (i_req),
        .d_req    (d_req),
        .pick_d_c (pick_d_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            store_q     <= 1'b0;
            i_ack       <= 1'b0;
            d_ack       <= 1'b0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            busy        <= 1'b0;
            owner_d     <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            store_q     <= store_nxt;
            i_ack       <= i_ack_nxt;
            d_ack       <= d_ack_nxt;
            i_rdata     <= i_rdata_nxt;
            d_rdata     <= d_rdata_nxt;
            mem_address <= mem_address_nxt;
            mem_data    <= mem_data_nxt;
            mem_wren    <= mem_wren_nxt;
            busy        <= busy_nxt;
            owner_d     <= owner_d_nxt;
        end
    end

    // Next state: fixed four-step sequence once granted.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:    if (grant_c) state_nxt = ST_ISSUE;
            ST_ISSUE:   state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        store_nxt       = store_q;
        i_ack_nxt       = 1'b0;
        d_ack_nxt       = 1'b0;
        i_rdata_nxt     = i_rdata;
        d_rdata_nxt     = d_rdata;
        mem_address_nxt = mem_address;
        mem_data_nxt    = mem_data;
        mem_wren_nxt    = 1'b0;
        owner_d_nxt     = owner_d;
        busy_nxt        = (state_nxt != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (grant_c) begin
                    owner_d_nxt     = pick_d_c;
                    mem_address_nxt = pick_d_c ? d_addr : i_addr;
                    mem_data_nxt    = pick_d_c ? d_wdata : mem_data;
                    mem_wren_nxt    = pick_d_c & d_we;
                    store_nxt       = pick_d_c & d_we;
                end
            end
            ST_CAPTURE: begin
                // RAM sampled the address on the previous edge, so mem_q is valid now.
                if (owner_d == OWNER_D) begin
                    d_ack_nxt = 1'b1;
                    if (!store_q) begin
                        d_rdata_nxt = mem_q;
                    end
                end else begin
                    i_ack_nxt   = 1'b1;
                    i_rdata_nxt = mem_q;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter with a behavioural 1-cycle-latency RAM.
// Expected acks are queued when a request is driven and checked by a monitor on each ack.
module tb_mips_mem_arbiter;

    typedef struct packed {
        logic        is_d;
        logic        chk;
        logic [31:0] data;
    } exp_t;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [9:0]  i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic [9:0]  mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;
    logic        busy;
    logic        owner_d;

    logic [31:0] ram [0:1023];
    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    bit          exp_last_d = 1'b0;

    mips_mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_ack       (i_ack),
        .i_rdata     (i_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_ack       (d_ack),
        .d_rdata     (d_rdata),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q),
        .busy        (busy),
        .owner_d     (owner_d)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, read data one cycle after the address edge.
    always @(posedge clk) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        mem_q <= ram[mem_address];
    end

    // Scoreboard monitor: every ack must match the oldest queued expectation.
    always @(negedge clk) begin
        if (i_ack || d_ack) begin
            checks++;
            if (i_ack && d_ack) begin
                errors++;
                $display("FAIL dual_ack i_ack=%b d_ack=%b required one-hot", i_ack, d_ack);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack i_ack=%b d_ack=%b required none", i_ack, d_ack);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (d_ack !== e.is_d) begin
                    errors++;
                    $display("FAIL ack_owner got d_ack=%b required %b", d_ack, e.is_d);
                end else if (e.chk && e.is_d && d_rdata !== e.data) begin
                    errors++;
                    $display("FAIL d_rdata got %h required %h", d_rdata, e.data);
                end else if (e.chk && !e.is_d && i_rdata !== e.data) begin
                    errors++;
                    $display("FAIL i_rdata got %h required %h", i_rdata, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({i_ack, d_ack, mem_wren, busy, owner_d} !== 5'b0 || i_rdata !== 32'h0 ||
            d_rdata !== 32'h0 || mem_address !== 10'h0 || mem_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_values acks=%b%b wren=%b busy=%b own=%b ir=%h dr=%h ma=%h md=%h required all 0",
                     i_ack, d_ack, mem_wren, busy, owner_d, i_rdata, d_rdata, mem_address, mem_data);
        end
        rst = 1'b0;
        exp_last_d = 1'b0;
    endtask

    // One uncontended request: grant, ack latency, bus contents and write strobe count.
    task automatic single(input bit is_d, input bit we, input logic [9:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_data);
        exp_t e;
        int   n;
        int   wren_cnt;
        bit   got;
        e.is_d = is_d; e.chk = !we; e.data = exp_data;
        sb.push_back(e);
        @(negedge clk);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        n = 0; wren_cnt = 0; got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (mem_wren) wren_cnt++;
            if (n == 1) begin
                checks++;
                if (busy !== 1'b1 || owner_d !== is_d || mem_address !== addr) begin
                    errors++;
                    $display("FAIL grant busy=%b owner_d=%b addr=%h required 1 %b %h",
                             busy, owner_d, mem_address, is_d, addr);
                end
                if (we) begin
                    checks++;
                    if (mem_data !== wdata) begin
                        errors++;
                        $display("FAIL mem_data got %h required %h", mem_data, wdata);
                    end
                end
            end
            if (is_d ? d_ack : i_ack) begin
                got = 1'b1;
                checks++;
                if (n !== 3) begin
                    errors++;
                    $display("FAIL ack_latency got %0d required 3", n);
                end
                i_req = 1'b0; d_req = 1'b0;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL ack_timeout got none required ack within 10 cycles");
            i_req = 1'b0; d_req = 1'b0;
        end
        d_we = 1'b0;
        @(negedge clk);
        checks++;
        if (i_ack || d_ack || busy) begin
            errors++;
            $display("FAIL after_ack i_ack=%b d_ack=%b busy=%b required 0 0 0", i_ack, d_ack, busy);
        end
        checks++;
        if (wren_cnt !== (we ? 1 : 0)) begin
            errors++;
            $display("FAIL wren_cycles got %0d required %0d", wren_cnt, we ? 1 : 0);
        end
        exp_last_d = is_d;
    endtask

    task automatic test_i_only();
        single(1'b0, 1'b0, 10'h004, 32'h0, 32'h20080005);
    endtask

    task automatic test_store_load();
        single(1'b1, 1'b1, 10'h010, 32'hDEADBEEF, 32'h0);
        single(1'b1, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF);
        checks++;
        if (i_rdata !== 32'h20080005) begin
            errors++;
            $display("FAIL i_rdata_hold got %h required 20080005", i_rdata);
        end
    endtask

    // Both requesters assert together; winner acks at 3, loser (still holding) at 7.
    task automatic contend();
        exp_t e;
        bit   w_d;
        bit   got_w;
        bit   got_l;
        int   n;
        w_d = RR ? !exp_last_d : 1'b1;
        e.chk = 1'b1;
        e.is_d = w_d;  e.data = w_d ? 32'hA5000002 : 32'hA5000001; sb.push_back(e);
        e.is_d = !w_d; e.data = w_d ? 32'hA5000001 : 32'hA5000002; sb.push_back(e);
        @(negedge clk);
        i_req = 1'b1; i_addr = 10'h001;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h002;
        n = 0; got_w = 1'b0; got_l = 1'b0;
        while (!(got_w && got_l) && n < 16) begin
            @(negedge clk);
            n++;
            if (!got_w && (w_d ? d_ack : i_ack)) begin
                got_w = 1'b1;
                checks++;
                if (n !== 3) begin
                    errors++;
                    $display("FAIL winner_ack_cycle got %0d required 3", n);
                end
                if (w_d) d_req = 1'b0; else i_req = 1'b0;
            end else if (!got_l && (w_d ? i_ack : d_ack)) begin
                got_l = 1'b1;
                checks++;
                if (n !== 7) begin
                    errors++;
                    $display("FAIL loser_ack_cycle got %0d required 7", n);
                end
                if (w_d) i_req = 1'b0; else d_req = 1'b0;
            end
        end
        if (!(got_w && got_l)) begin
            checks++; errors++;
            $display("FAIL contend_timeout got w=%b l=%b required both acks", got_w, got_l);
            i_req = 1'b0; d_req = 1'b0;
        end
        @(negedge clk);
        exp_last_d = !w_d;
    endtask

    task automatic test_contention();
        test_reset();
        contend();
        single(1'b1, 1'b0, 10'h005, 32'h0, 32'hA5000005);
        contend();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   acks;
        e.is_d = 1'b0; e.chk = 1'b1; e.data = 32'hA5000003;
        for (int k = 0; k < 4; k++) sb.push_back(e);
        @(negedge clk);
        i_req = 1'b1; i_addr = 10'h003;
        acks = 0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (i_ack) begin
                checks++;
                if (n !== 3 + 4 * acks) begin
                    errors++;
                    $display("FAIL b2b_ack_cycle got %0d required %0d", n, 3 + 4 * acks);
                end
                acks++;
            end
            if (n == 16) i_req = 1'b0;
        end
        checks++;
        if (acks !== 4) begin
            errors++;
            $display("FAIL b2b_ack_count got %0d required 4", acks);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle busy=%b required 0", busy);
        end
        exp_last_d = 1'b0;
    endtask

    task automatic test_reset_in_issue();
        int stray;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'h020; d_wdata = 32'h12345678;
        @(negedge clk);
        checks++;
        if (mem_wren !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL issue_state wren=%b busy=%b required 1 1", mem_wren, busy);
        end
        rst = 1'b1; d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || d_ack !== 1'b0 || mem_wren !== 1'b0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_in_issue busy=%b d_ack=%b wren=%b d_rdata=%h required 0 0 0 0",
                     busy, d_ack, mem_wren, d_rdata);
        end
        rst = 1'b0;
        exp_last_d = 1'b0;
        stray = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (d_ack || i_ack) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL no_ack_after_rst got %0d acks required 0", stray);
        end
        single(1'b1, 1'b0, 10'h020, 32'h0, 32'h12345678);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'hA5000000 | 32'(i);
        ram[4] = 32'h20080005;
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        test_reset();
        test_i_only();
        test_store_load();
        test_contention();
        test_back_to_back();
        test_reset_in_issue();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
